// File: rtl/l2_req_responder.sv
// ============================================================================
// Module  : l2_req_responder
// Brief   : Fixed-latency L2 request responder backed by a small line store.
// Revision: 1.0
// ============================================================================
`default_nettype none

module l2_req_responder #(
    parameter int LAT        = 4,
    parameter int DEPTH_LOG2 = 4,
    parameter int LINE_BITS  = 128,
    parameter int ADDR_BITS  = 28
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 l2_req_out_valid,
    output logic                 l2_req_out_ready,
    input  logic [4:0]           l2_req_out_data_coh_msg,
    input  logic [1:0]           l2_req_out_data_hprot,
    input  logic [ADDR_BITS-1:0] l2_req_out_data_addr,
    input  logic [LINE_BITS-1:0] l2_req_out_data_line,
    output logic                 l2_rsp_in_valid,
    input  logic                 l2_rsp_in_ready,
    output logic [4:0]           l2_rsp_in_data_coh_msg,
    output logic [ADDR_BITS-1:0] l2_rsp_in_data_addr,
    output logic [LINE_BITS-1:0] l2_rsp_in_data_line,
    output logic [3:0]           l2_rsp_in_data_invack_cnt,
    output logic [7:0]           err_cnt
);

    localparam int         C_DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [3:0] C_LAT        = 4'(LAT);
    localparam logic [4:0] C_REQ_V      = 5'd0;
    localparam logic [4:0] C_REQ_S      = 5'd1;
    localparam logic [4:0] C_REQ_O      = 5'd2;
    localparam logic [4:0] C_REQ_WT     = 5'd3;
    localparam logic [4:0] C_REQ_WB     = 5'd4;
    localparam logic [4:0] C_RSP_WB_ACK = 5'd4;
    localparam logic [4:0] C_RSP_NACK   = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic                   r_req_ready;
    logic                   r_rsp_valid;
    logic [4:0]             r_rsp_coh;
    logic [ADDR_BITS-1:0]   r_rsp_addr;
    logic [LINE_BITS-1:0]   r_rsp_line;
    logic [1:0]             r_hprot_unused;
    logic [7:0]             r_err_cnt;
    logic [LINE_BITS-1:0]   r_store [C_DEPTH];

    logic [DEPTH_LOG2-1:0]  w_idx;
    logic                   w_accept;

    // Upper address bits alias onto the same store line.
    assign w_idx    = l2_req_out_data_addr[DEPTH_LOG2-1:0];
    assign w_accept = l2_req_out_valid && r_req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= 4'd0;
            r_req_ready    <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_coh      <= 5'd0;
            r_rsp_addr     <= '0;
            r_rsp_line     <= '0;
            r_hprot_unused <= 2'd0;
            r_err_cnt      <= 8'd0;
            for (int i = 0; i < C_DEPTH; i++) begin
                r_store[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req_ready    <= 1'b0;
                        r_rsp_addr     <= l2_req_out_data_addr;
                        r_hprot_unused <= l2_req_out_data_hprot;
                        r_cnt          <= C_LAT;
                        // Read data and store updates are resolved at capture.
                        case (l2_req_out_data_coh_msg)
                            C_REQ_V, C_REQ_S, C_REQ_O: begin
                                r_rsp_coh  <= l2_req_out_data_coh_msg;
                                r_rsp_line <= r_store[w_idx];
                            end
                            C_REQ_WT, C_REQ_WB: begin
                                r_rsp_coh      <= (l2_req_out_data_coh_msg == C_REQ_WT) ?
                                                  C_REQ_WT : C_RSP_WB_ACK;
                                r_rsp_line     <= '0;
                                r_store[w_idx] <= l2_req_out_data_line;
                            end
                            default: begin
                                r_rsp_coh  <= C_RSP_NACK;
                                r_rsp_line <= '0;
                                if (r_err_cnt != 8'hFF) begin
                                    r_err_cnt <= r_err_cnt + 8'd1;
                                end
                            end
                        endcase
                        if (C_LAT == 4'd0) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_cnt       <= 4'd0;
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (l2_rsp_in_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b0;
                end
            endcase
        end
    end

    assign l2_req_out_ready          = r_req_ready;
    assign l2_rsp_in_valid           = r_rsp_valid;
    assign l2_rsp_in_data_coh_msg    = r_rsp_coh;
    assign l2_rsp_in_data_addr       = r_rsp_addr;
    assign l2_rsp_in_data_line       = r_rsp_line;
    assign l2_rsp_in_data_invack_cnt = 4'd0;
    assign err_cnt                   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_l2_req_responder.sv
// ============================================================================
// Module  : tb_l2_req_responder
// Brief   : Directed self-checking bench for l2_req_responder (LAT=4 and LAT=0).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_l2_req_responder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    // DUT A: default latency
    logic         a_valid = 1'b0;
    logic         a_ready;
    logic [4:0]   a_coh = 5'd0;
    logic [1:0]   a_hprot = 2'd0;
    logic [27:0]  a_addr = 28'd0;
    logic [127:0] a_line = 128'd0;
    logic         a_rsp_valid;
    logic         a_rsp_ready = 1'b0;
    logic [4:0]   a_rsp_coh;
    logic [27:0]  a_rsp_addr;
    logic [127:0] a_rsp_line;
    logic [3:0]   a_rsp_inv;
    logic [7:0]   a_err;

    // DUT B: zero latency, response always accepted
    logic         b_valid = 1'b0;
    logic         b_ready;
    logic         b_rsp_valid;
    logic [4:0]   b_rsp_coh;
    logic [27:0]  b_rsp_addr;
    logic [127:0] b_rsp_line;
    logic [3:0]   b_rsp_inv;
    logic [7:0]   b_err;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] C_A5 = {16{8'hA5}};

    always #5 clk = ~clk;

    l2_req_responder #(.LAT(4), .DEPTH_LOG2(4), .LINE_BITS(128), .ADDR_BITS(28)) u_dut_a (
        .clk                       (clk),
        .rst                       (rst),
        .l2_req_out_valid          (a_valid),
        .l2_req_out_ready          (a_ready),
        .l2_req_out_data_coh_msg   (a_coh),
        .l2_req_out_data_hprot     (a_hprot),
        .l2_req_out_data_addr      (a_addr),
        .l2_req_out_data_line      (a_line),
        .l2_rsp_in_valid           (a_rsp_valid),
        .l2_rsp_in_ready           (a_rsp_ready),
        .l2_rsp_in_data_coh_msg    (a_rsp_coh),
        .l2_rsp_in_data_addr       (a_rsp_addr),
        .l2_rsp_in_data_line       (a_rsp_line),
        .l2_rsp_in_data_invack_cnt (a_rsp_inv),
        .err_cnt                   (a_err)
    );

    l2_req_responder #(.LAT(0), .DEPTH_LOG2(4), .LINE_BITS(128), .ADDR_BITS(28)) u_dut_b (
        .clk                       (clk),
        .rst                       (rst),
        .l2_req_out_valid          (b_valid),
        .l2_req_out_ready          (b_ready),
        .l2_req_out_data_coh_msg   (5'd1),
        .l2_req_out_data_hprot     (2'd0),
        .l2_req_out_data_addr      (28'h0000042),
        .l2_req_out_data_line      (128'd0),
        .l2_rsp_in_valid           (b_rsp_valid),
        .l2_rsp_in_ready           (1'b1),
        .l2_rsp_in_data_coh_msg    (b_rsp_coh),
        .l2_rsp_in_data_addr       (b_rsp_addr),
        .l2_rsp_in_data_line       (b_rsp_line),
        .l2_rsp_in_data_invack_cnt (b_rsp_inv),
        .err_cnt                   (b_err)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on DUT A; returns cycles from accept to rsp_valid (99 on timeout).
    task automatic do_req(input logic [4:0] op, input logic [27:0] addr,
                          input logic [127:0] line, output int lat);
        int n;
        n = 0;
        while (!a_ready && n < 50) begin
            step();
            n++;
        end
        if (!a_ready) check("req_ready_timeout", 0, 1);
        a_coh   = op;
        a_addr  = addr;
        a_line  = line;
        a_hprot = 2'd3;
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        lat = 1;
        while (!a_rsp_valid && lat < 50) begin
            step();
            lat++;
        end
        if (!a_rsp_valid) lat = 99;
    endtask

    task automatic finish_rsp();
        a_rsp_ready = 1'b1;
        step();
        a_rsp_ready = 1'b0;
        check("done_rsp_valid", a_rsp_valid, 0);
        check("done_req_ready", a_ready, 1);
    endtask

    initial begin
        int lat;
        logic [4:0] op;

        // Reset state
        #12;
        check("rst_req_ready", a_ready, 0);
        check("rst_rsp_valid", a_rsp_valid, 0);
        check("rst_err_cnt", a_err, 0);
        check("rst_rsp_line", a_rsp_line, 0);
        check("rst_rsp_coh", a_rsp_coh, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        b_valid = 1'b1;
        check("post_rst_ready_low", a_ready, 0);
        step();
        check("post_rst_ready_high", a_ready, 1);

        // LAT=0: accept every other cycle, response the cycle after accept
        for (int i = 0; i < 5; i++) begin
            check("b_req_ready", b_ready, 1);
            check("b_rsp_idle", b_rsp_valid, 0);
            step();
            check("b_rsp_valid", b_rsp_valid, 1);
            check("b_req_busy", b_ready, 0);
            check("b_rsp_coh", b_rsp_coh, 5'd1);
            check("b_rsp_addr", b_rsp_addr, 28'h42);
            step();
        end
        b_valid = 1'b0;

        // REQ_S to 0x5: five cycles accept-to-valid
        do_req(5'd1, 28'h5, 128'd0, lat);
        check("s_latency", lat, 5);
        check("s_coh", a_rsp_coh, 5'd1);
        check("s_line", a_rsp_line, 0);
        check("s_addr", a_rsp_addr, 28'h5);
        check("s_invack", a_rsp_inv, 0);
        check("s_req_ready", a_ready, 0);
        finish_rsp();

        // WB to 0x13 then V to aliasing 0x3
        do_req(5'd4, 28'h13, C_A5, lat);
        check("wb_coh", a_rsp_coh, 5'd4);
        check("wb_line", a_rsp_line, 0);
        check("wb_addr", a_rsp_addr, 28'h13);
        finish_rsp();
        do_req(5'd0, 28'h3, 128'd0, lat);
        check("v_alias_coh", a_rsp_coh, 5'd0);
        check("v_alias_line", a_rsp_line, C_A5);
        finish_rsp();

        // WT then O through an aliasing address
        do_req(5'd3, 28'h7, 128'h1234_5678, lat);
        check("wt_coh", a_rsp_coh, 5'd3);
        check("wt_line", a_rsp_line, 0);
        finish_rsp();
        do_req(5'd2, 28'h27, 128'd0, lat);
        check("o_coh", a_rsp_coh, 5'd2);
        check("o_line", a_rsp_line, 128'h1234_5678);
        check("o_addr", a_rsp_addr, 28'h27);
        finish_rsp();

        // Backpressure: response held stable for 10 cycles
        do_req(5'd1, 28'h13, 128'd0, lat);
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_valid", a_rsp_valid, 1);
            check("stall_line", a_rsp_line, C_A5);
            check("stall_coh", a_rsp_coh, 5'd1);
            check("stall_req_ready", a_ready, 0);
        end
        finish_rsp();

        // Bad opcode: NACK, no store write
        do_req(5'd7, 28'h3, 128'hFFFF, lat);
        check("nack_coh", a_rsp_coh, 5'd31);
        check("nack_line", a_rsp_line, 0);
        check("nack_err", a_err, 1);
        finish_rsp();
        do_req(5'd0, 28'h3, 128'd0, lat);
        check("nack_store_kept", a_rsp_line, C_A5);
        finish_rsp();

        // Saturate error counter
        for (int i = 0; i < 253; i++) begin
            op = 5'(5 + (i % 27));
            do_req(op, 28'(i), 128'd0, lat);
            finish_rsp();
        end
        check("err_254", a_err, 8'd254);
        for (int i = 0; i < 47; i++) begin
            do_req(5'd31, 28'h1, 128'd0, lat);
            finish_rsp();
        end
        check("err_sat", a_err, 8'd255);

        // Reset in WAIT after a WT
        while (!a_ready) step();
        a_coh = 5'd3; a_addr = 28'h3; a_line = 128'hDEAD; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        check("arst_rsp_valid", a_rsp_valid, 0);
        check("arst_req_ready", a_ready, 0);
        check("arst_err", a_err, 0);
        step();
        check("arst_hold_valid", a_rsp_valid, 0);
        rst = 1'b0;
        check("arst_ready_low", a_ready, 0);
        step();
        check("arst_ready_back", a_ready, 1);
        check("arst_valid_still0", a_rsp_valid, 0);
        do_req(5'd0, 28'h3, 128'd0, lat);
        check("arst_store_zero", a_rsp_line, 0);
        check("arst_latency", lat, 5);
        finish_rsp();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/l2_req_responder.md
L2_REQ_RESPONDER -- requirements
Module: l2_req_responder

Interface
REQ-001 SHALL have parameter LAT, default 4, meaning idle cycles between request capture and response assertion; legal range 0..15.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, meaning log2 of backing-store line count.
REQ-003 SHALL have parameter LINE_BITS, default 128, meaning cache line width.
REQ-004 SHALL have parameter ADDR_BITS, default 28, meaning line-address width.
REQ-005 SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous active-high reset.
- l2_req_out_valid  in  1  L2 request present.
- l2_req_out_ready  out  1  responder accepts request.
- l2_req_out_data_coh_msg  in  5  request opcode.
- l2_req_out_data_hprot  in  2  protection bits; captured, not interpreted.
- l2_req_out_data_addr  in  ADDR_BITS  line address.
- l2_req_out_data_line  in  LINE_BITS  write data.
- l2_rsp_in_valid  out  1  response to L2 present.
- l2_rsp_in_ready  in  1  L2 accepts response.
- l2_rsp_in_data_coh_msg  out  5  response opcode.
- l2_rsp_in_data_addr  out  ADDR_BITS  echoed line address.
- l2_rsp_in_data_line  out  LINE_BITS  read data, or zero for acks.
- l2_rsp_in_data_invack_cnt  out  4  always zero.
- err_cnt  out  8  count of unsupported opcodes; saturates at 255.

Function
REQ-006 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-007 SHALL drive l2_req_out_ready high only in IDLE.
REQ-008 SHALL, on valid&&ready in IDLE, capture opcode, address, and line; load the latency counter with LAT; go to WAIT, or directly to RESP if LAT=0.
REQ-009 SHALL, in WAIT, decrement the counter each cycle and enter RESP on the cycle after the counter reaches 1.
REQ-010 SHALL index the backing store with addr[DEPTH_LOG2-1:0]; upper address bits are ignored (aliasing permitted).
REQ-011 SHALL apply the following opcode map, with side effects occurring on the capture edge:
- REQ_V=0 -> RSP_V=0 with stored line.
- REQ_S=1 -> RSP_S=1 with stored line.
- REQ_O=2 -> RSP_O=2 with stored line.
- REQ_WT=3 -> RSP_WT=3, line zero, store written.
- REQ_WB=4 -> RSP_WB_ACK=4, line zero, store written.
- other -> RSP_NACK=31, line zero, no store write, err_cnt+1.
REQ-012 SHALL hold l2_rsp_in_valid and all response data stable in RESP until l2_rsp_in_ready is high, then return to IDLE on that edge.
REQ-013 SHALL make read data reflect the store contents at capture time, so a write to the same index followed by a read returns the new data.
REQ-014 SHALL support back-to-back operation: the minimum request-to-request spacing is LAT+2 cycles, because ready is low outside IDLE.
REQ-015 SHALL echo the captured address on l2_rsp_in_data_addr.

Reset
REQ-016 SHALL, on rst assertion (including mid-WAIT or mid-RESP), asynchronously force IDLE, l2_rsp_in_valid=0, l2_req_out_ready=0 while rst is high, all response data=0, counter=0, err_cnt=0, and all store lines=0.
REQ-017 SHALL raise l2_req_out_ready on the first clk edge after rst deasserts; any in-flight response is dropped.

Verification
REQ-018 Reset, then REQ_S to addr 0x5 with LAT=4 -> rsp_valid rises 5 cycles after accept; RSP_S, line=0, addr=0x5, invack_cnt=0.
REQ-019 REQ_WB addr 0x13 line 0xA5..A5, then REQ_V addr 0x3 -> RSP_WB_ACK, then RSP_V with line 0xA5..A5 (alias).
REQ-020 Hold rsp_ready low 10 cycles in RESP -> valid and data stable throughout; req_ready stays low; completion occurs on the first ready cycle.
REQ-021 Opcode 7 -> RSP_NACK, err_cnt=1, store unchanged; 300 bad opcodes -> err_cnt=255.
REQ-022 Assert rst during WAIT after a REQ_WT -> valid stays 0, store=0, req_ready returns 1 cycle after deassert.
REQ-023 LAT=0, rsp_ready tied high -> response valid the cycle after accept; requests accepted every 2 cycles.
